// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: operation and mode encodings,
// the queued command record, the sequencer states and the flag-keeping rules.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ADD         = 3'd0,
    SUB         = 3'd1,
    MUL         = 3'd2,
    DIV         = 3'd3,
    LEFT_SHIFT  = 3'd4,
    RIGHT_SHIFT = 3'd5,
    RESERVED_6  = 3'd6,
    RESERVED_7  = 3'd7
  } alu_operation;

  typedef enum logic {
    SIGN   = 1'b0,
    UNSIGN = 1'b1
  } operation_mode;

  typedef union packed {
    logic        [DATA_W-1:0] bits;
    logic signed [DATA_W-1:0] value;
  } data_t;

  typedef struct packed {
    alu_operation  op;
    operation_mode mode;
    data_t         a;
    data_t         b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } seq_state_t;

  function automatic logic is_legal_op(input alu_operation op);
    return (op != RESERVED_6) && (op != RESERVED_7);
  endfunction

  // Carry only means something for unsigned add/sub, overflow only for signed add/sub.
  function automatic logic keep_carry(input alu_operation op, input operation_mode mode);
    return (mode == UNSIGN) && ((op == ADD) || (op == SUB));
  endfunction

  function automatic logic keep_overflow(input alu_operation op, input operation_mode mode);
    return (mode == SIGN) && ((op == ADD) || (op == SUB));
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the sequencer: DEPTH entries of alu_cmd_t, head visible
// combinationally, extra pointer bit distinguishes full from empty.
module alu_cmd_fifo import alu_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     push,
  input  logic     pop,
  input  alu_cmd_t wr_data,
  output alu_cmd_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  alu_cmd_t    mem_r [DEPTH];
  logic        do_push_s;
  logic        do_pop_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{op: ADD, mode: SIGN, a: 8'h00, b: 8'h00};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds queued commands to the registered-input 8-bit ALU one at a time and
// returns cleaned results on a valid/ready port. Optional: DIV_BY_ZERO_TRAP_EN.
module alu_cmd_sequencer import alu_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_mode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [2:0]        alu_op,
  output logic              alu_mode,
  output logic [DATA_W-1:0] alu_value1,
  output logic [DATA_W-1:0] alu_value2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_c_out,
  input  logic              alu_overflow,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_c_out,
  output logic              res_overflow,
  output logic              res_zero,
  output logic              res_err
);

  seq_state_t        state_r;
  seq_state_t        next_state_s;
  alu_cmd_t          wr_cmd_s;
  alu_cmd_t          head_s;
  alu_cmd_t          issued_r;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              pop_s;
  logic              bypass_s;
  logic [DATA_W-1:0] bypass_data_s;
  logic              clean_c_s;
  logic              clean_ov_s;

  always_comb begin
    wr_cmd_s.op     = alu_operation'(cmd_op);
    wr_cmd_s.mode   = operation_mode'(cmd_mode);
    wr_cmd_s.a.bits = cmd_a;
    wr_cmd_s.b.bits = cmd_b;
  end

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (cmd_valid),
    .pop     (pop_s),
    .wr_data (wr_cmd_s),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign cmd_ready  = !fifo_full_s;
  assign alu_op     = issued_r.op;
  assign alu_mode   = issued_r.mode;
  assign alu_value1 = issued_r.a.bits;
  assign alu_value2 = issued_r.b.bits;

  // Commands that never reach the ALU produce their result straight from the head entry.
  always_comb begin
    bypass_s      = 1'b0;
    bypass_data_s = {DATA_W{1'b0}};
    if (!is_legal_op(head_s.op)) begin
      bypass_s      = 1'b1;
      bypass_data_s = {DATA_W{1'b0}};
    end
`ifdef DIV_BY_ZERO_TRAP_EN
    else if ((head_s.op == DIV) && (head_s.b.bits == {DATA_W{1'b0}})) begin
      bypass_s      = 1'b1;
      bypass_data_s = {DATA_W{1'b1}};
    end
`endif
    else begin
      bypass_s      = 1'b0;
      bypass_data_s = {DATA_W{1'b0}};
    end
  end

  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          next_state_s = bypass_s ? HOLD : ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE:   next_state_s = CAPTURE;
      CAPTURE: next_state_s = HOLD;
      HOLD: begin
        if (res_ready && !fifo_empty_s) begin
          pop_s        = 1'b1;
          next_state_s = bypass_s ? HOLD : ISSUE;
        end else if (res_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issued_r <= '{op: ADD, mode: SIGN, a: 8'h00, b: 8'h00};
    end else if (pop_s && !bypass_s) begin
      issued_r <= head_s;
    end else begin
      issued_r <= issued_r;
    end
  end

  // The ALU's flag outputs are undefined for most operations, so never pass them through raw.
  always_comb begin
    clean_c_s  = 1'b0;
    clean_ov_s = 1'b0;
    if (keep_carry(issued_r.op, issued_r.mode)) begin
      clean_c_s = (alu_c_out === 1'b1);
    end else begin
      clean_c_s = 1'b0;
    end
    if (keep_overflow(issued_r.op, issued_r.mode)) begin
      clean_ov_s = (alu_overflow === 1'b1);
    end else begin
      clean_ov_s = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_valid    <= 1'b0;
      res_data     <= {DATA_W{1'b0}};
      res_c_out    <= 1'b0;
      res_overflow <= 1'b0;
      res_zero     <= 1'b0;
      res_err      <= 1'b0;
    end else if (state_r == CAPTURE) begin
      res_valid    <= 1'b1;
      res_data     <= alu_out;
      res_c_out    <= clean_c_s;
      res_overflow <= clean_ov_s;
      res_zero     <= (alu_out == {DATA_W{1'b0}});
      res_err      <= 1'b0;
    end else if (pop_s && bypass_s) begin
      res_valid    <= 1'b1;
      res_data     <= bypass_data_s;
      res_c_out    <= 1'b0;
      res_overflow <= 1'b0;
      res_zero     <= 1'b0;
      res_err      <= 1'b1;
    end else if ((state_r == HOLD) && res_ready) begin
      res_valid    <= 1'b0;
    end else begin
      res_valid    <= res_valid;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural registered-input ALU.
// Expected results are pushed at command issue and popped by a result monitor.
module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic [7:0] data;
    logic       c;
    logic       ov;
    logic       z;
    logic       err;
  } res_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic       cmd_mode = 1'b0;
  logic [7:0] cmd_a = 8'd0;
  logic [7:0] cmd_b = 8'd0;
  logic [2:0] alu_op;
  logic       alu_mode;
  logic [7:0] alu_value1;
  logic [7:0] alu_value2;
  logic [7:0] alu_out = 8'd0;
  logic       alu_c_out = 1'b0;
  logic       alu_overflow = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_c_out;
  logic       res_overflow;
  logic       res_zero;
  logic       res_err;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  res_t exp_q[$];
  int   hs_q[$];
  logic rec_en = 1'b0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  alu_cmd_sequencer #(.DEPTH(4), .DATA_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_mode(cmd_mode),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_mode(alu_mode), .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_out(alu_out), .alu_c_out(alu_c_out), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_c_out(res_c_out), .res_overflow(res_overflow), .res_zero(res_zero), .res_err(res_err)
  );

  // Behavioural ALU: registers its inputs, garbage flags (1) for non add/sub ops.
  logic [8:0] sum_w;
  logic [8:0] diff_w;
  assign sum_w  = {1'b0, alu_value1} + {1'b0, alu_value2};
  assign diff_w = {1'b0, alu_value1} - {1'b0, alu_value2};

  always @(posedge clock) begin
    case (alu_op)
      3'd0: begin
        alu_out      <= sum_w[7:0];
        alu_c_out    <= sum_w[8];
        alu_overflow <= (alu_value1[7] == alu_value2[7]) && (sum_w[7] != alu_value1[7]);
      end
      3'd1: begin
        alu_out      <= diff_w[7:0];
        alu_c_out    <= diff_w[8];
        alu_overflow <= (alu_value1[7] != alu_value2[7]) && (diff_w[7] != alu_value1[7]);
      end
      3'd2: begin alu_out <= alu_value1 * alu_value2; alu_c_out <= 1'b1; alu_overflow <= 1'b1; end
      3'd3: begin
        alu_out      <= (alu_value2 == 8'd0) ? 8'd0 : alu_value1 / alu_value2;
        alu_c_out    <= 1'b1;
        alu_overflow <= 1'b1;
      end
      3'd4: begin alu_out <= alu_value1 << alu_value2[2:0]; alu_c_out <= 1'b1; alu_overflow <= 1'b1; end
      3'd5: begin alu_out <= alu_value1 >> alu_value2[2:0]; alu_c_out <= 1'b1; alu_overflow <= 1'b1; end
      default: begin alu_out <= 8'hEE; alu_c_out <= 1'b1; alu_overflow <= 1'b1; end
    endcase
  end

  function automatic res_t mk(input logic [7:0] d, input logic c, input logic ov,
                              input logic z, input logic e);
    res_t r;
    r.data = d; r.c = c; r.ov = ov; r.z = z; r.err = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Result monitor: pops the scoreboard on every handshake and checks stall stability.
  task automatic monitor();
    res_t cur;
    res_t snap;
    res_t e;
    logic hold_prev;
    hold_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clock);
      cur = {res_data, res_c_out, res_overflow, res_zero, res_err};
      if (!reset_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          vectors++;
          if (!res_valid || cur != snap) begin
            miscompares++;
            $display("FAIL stall_stable: got v=%0b %h expected v=1 %h", res_valid, cur, snap);
          end
        end
        if (res_valid && res_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_result: got %h expected none", cur);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              miscompares++;
              $display("FAIL result: got data=%h c=%b ov=%b z=%b err=%b expected data=%h c=%b ov=%b z=%b err=%b",
                       cur.data, cur.c, cur.ov, cur.z, cur.err, e.data, e.c, e.ov, e.z, e.err);
            end
          end
          if (rec_en) hs_q.push_back(cyc);
        end
        hold_prev = res_valid && !res_ready;
        snap = cur;
      end
    end
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic mode, input logic [7:0] a,
                          input logic [7:0] b, input res_t e);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    cmd_op = op; cmd_mode = mode; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clock);
      if (cmd_ready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: got cmd_ready=0 expected 1 within 300 cycles");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge clock);
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_bus", {24'd0, res_data} | {28'd0, res_c_out, res_overflow, res_zero, res_err}, 32'd0);
    chk("rst_alu_bus", {17'd0, alu_op, alu_mode, alu_value1, alu_value2}, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // 1: unsigned add with latency probe
    res_ready = 1'b0;
    push_cmd(3'd0, 1'b1, 8'd200, 8'd100, mk(8'd44, 1'b1, 1'b0, 1'b0, 1'b0));
    @(negedge clock); chk("lat_after_push", {31'd0, res_valid}, 32'd0);
    @(negedge clock); chk("lat_after_pop", {31'd0, res_valid}, 32'd0);
    @(negedge clock); chk("lat_pop_plus1", {31'd0, res_valid}, 32'd0);
    @(negedge clock); chk("lat_pop_plus2", {31'd0, res_valid}, 32'd1);
    @(posedge clock); #1;
    res_ready = 1'b1;
    wait_drain();

    // 2: signed overflow and zero
    push_cmd(3'd0, 1'b0, 8'd100, 8'd100, mk(8'hC8, 1'b0, 1'b1, 1'b0, 1'b0));
    push_cmd(3'd1, 1'b0, 8'd5, 8'd5, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    wait_drain();

    // 3: fill FIFO behind a stalled result
    res_ready = 1'b0;
    push_cmd(3'd0, 1'b1, 8'd1, 8'd2, mk(8'h03, 1'b0, 1'b0, 1'b0, 1'b0));
    push_cmd(3'd1, 1'b1, 8'd3, 8'd10, mk(8'hF9, 1'b1, 1'b0, 1'b0, 1'b0));
    push_cmd(3'd2, 1'b0, 8'd3, 8'd4, mk(8'h0C, 1'b0, 1'b0, 1'b0, 1'b0));
    push_cmd(3'd3, 1'b1, 8'd100, 8'd7, mk(8'h0E, 1'b0, 1'b0, 1'b0, 1'b0));
    push_cmd(3'd4, 1'b1, 8'h81, 8'd1, mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clock);
    chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("full_res_valid", {31'd0, res_valid}, 32'd1);
    repeat (4) @(posedge clock);
    #1;
    res_ready = 1'b1;
    wait_drain();

    // 4: illegal op leaves ALU inputs untouched; divide by zero
    push_cmd(3'd7, 1'b0, 8'h55, 8'h66, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    wait_drain();
    chk("illegal_alu_hold", {17'd0, alu_op, alu_mode, alu_value1, alu_value2},
        {17'd0, 3'd4, 1'b1, 8'h81, 8'h01});
`ifdef DIV_BY_ZERO_TRAP_EN
    push_cmd(3'd3, 1'b0, 8'd10, 8'd0, mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
    wait_drain();
    chk("div0_alu_op", {29'd0, alu_op}, 32'd4);
`else
    push_cmd(3'd3, 1'b0, 8'd10, 8'd0, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    wait_drain();
    chk("div0_alu_op", {29'd0, alu_op}, 32'd3);
`endif

    // 5: reset in CAPTURE
    res_ready = 1'b0;
    push_cmd(3'd0, 1'b0, 8'd1, 8'd1, mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("postrst_idle", {31'd0, res_valid}, 32'd0);
    @(posedge clock); #1;
    res_ready = 1'b1;
    push_cmd(3'd0, 1'b0, 8'd7, 8'd8, mk(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_drain();

    // 6: back-to-back multiplies
    hs_q.delete();
    rec_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] k;
      k = 8'(i + 1);
      push_cmd(3'd2, 1'b1, k, 8'd3, mk(k * 8'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    wait_drain();
    rec_en = 1'b0;
    chk("mul_count", hs_q.size(), 32'd8);
    for (int i = 1; i < hs_q.size(); i++) begin
      chk("mul_spacing", hs_q[i] - hs_q[i-1], 32'd3);
    end

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
